// File: rtl/fg_seq_pkg.sv
// Shared types and constants for the f/g modulo-4 sequence checker.
// Optional error counter is enabled by defining FG_ERR_CNT_EN.
package fg_seq_pkg;

    localparam int              CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

    localparam logic [1:0] SYM_00 = 2'b00;
    localparam logic [1:0] SYM_01 = 2'b01;
    localparam logic [1:0] SYM_10 = 2'b10;
    localparam logic [1:0] SYM_11 = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        S0,
        S1,
        S2,
        S3
    } state_e;

    // Map a symbol to the state that records it as the last accepted symbol.
    function automatic state_e sym_state(input logic [1:0] sym);
        case (sym)
            SYM_00:  return S0;
            SYM_01:  return S1;
            SYM_10:  return S2;
            default: return S3;
        endcase
    endfunction

    function automatic logic [1:0] state_sym(input state_e st);
        case (st)
            S1:      return SYM_01;
            S2:      return SYM_10;
            S3:      return SYM_11;
            default: return SYM_00;
        endcase
    endfunction

endpackage

// File: rtl/fg_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Clear has priority over increment; the count sticks at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fg_seq_checker.sv
// Checks that {f,g} steps through 00->01->10->11, pulsing DET on each completed pass.
// Define FG_ERR_CNT_EN to add the ECNT saturating error counter port.
module fg_seq_checker
    import fg_seq_pkg::*;
(
    input  logic             CLK1,
    input  logic             RST,
    input  logic             f,
    input  logic             g,
    input  logic             CLR,
    output logic             DET,
    output logic             ERR,
    output logic [CNT_W-1:0] CNT
`ifdef FG_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] ECNT
`endif
);

    logic [1:0] sym;
    state_e     state_q;
    state_e     state_d;
    logic       det_evt;
    logic       err_evt;
    logic       det_q;
    logic       err_q;

    assign sym = {f, g};

    // A symbol may repeat or advance by one (mod 4); anything else breaks the sequence.
    always_comb begin
        state_d = state_q;
        det_evt = 1'b0;
        err_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (sym == SYM_00) begin
                    state_d = S0;
                end
            end
            S0, S1, S2, S3: begin
                if (sym == state_sym(state_q)) begin
                    state_d = state_q;
                end else if (sym == state_sym(state_q) + 2'd1) begin
                    state_d = sym_state(sym);
                    det_evt = (sym == SYM_11);
                end else begin
                    state_d = IDLE;
                    err_evt = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK1 or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            det_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            det_q   <= det_evt;
            err_q   <= CLR ? 1'b0 : (err_q | err_evt);
        end
    end

    assign DET = det_q;
    assign ERR = err_q;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_det_cnt (
        .clk_i   (CLK1),
        .rst_ni  (RST),
        .inc_i   (det_evt),
        .clr_i   (CLR),
        .count_o (CNT)
    );

`ifdef FG_ERR_CNT_EN
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_err_cnt (
        .clk_i   (CLK1),
        .rst_ni  (RST),
        .inc_i   (err_evt),
        .clr_i   (CLR),
        .count_o (ECNT)
    );
`endif

endmodule

// File: tb/tb_fg_seq_checker.sv
// Scoreboard testbench for fg_seq_checker; directed scenarios followed by biased random symbols.
// Honours FG_ERR_CNT_EN to also check ECNT.
module tb_fg_seq_checker;

    typedef struct {
        logic       det;
        logic       err;
        logic [7:0] cnt;
        logic [7:0] ecnt;
    } exp_t;

    logic       CLK1;
    logic       RST;
    logic       f;
    logic       g;
    logic       CLR;
    logic       DET;
    logic       ERR;
    logic [7:0] CNT;
`ifdef FG_ERR_CNT_EN
    logic [7:0] ECNT;
`endif

    int   checks;
    int   errors;
    int   detPulses;
    exp_t expQ[$];

    // Reference model: last accepted symbol index, -1 when no sequence is in progress.
    int   mLast;
    logic mErr;
    int   mCnt;
    int   mEcnt;

    fg_seq_checker dut (
        .CLK1 (CLK1),
        .RST  (RST),
        .f    (f),
        .g    (g),
        .CLR  (CLR),
        .DET  (DET),
        .ERR  (ERR),
        .CNT  (CNT)
`ifdef FG_ERR_CNT_EN
        ,
        .ECNT (ECNT)
`endif
    );

    initial CLK1 = 1'b0;
    always #5 CLK1 = ~CLK1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mLast = -1;
        mErr  = 1'b0;
        mCnt  = 0;
        mEcnt = 0;
    endtask

    task automatic applyStimulus(input int sym, input bit clr);
        exp_t e;
        bit   detEv;
        bit   errEv;
        @(negedge CLK1);
        f   = sym[1];
        g   = sym[0];
        CLR = clr;
        detEv = 1'b0;
        errEv = 1'b0;
        if (mLast < 0) begin
            if (sym == 0) mLast = 0;
        end else if (sym == mLast) begin
            mLast = sym;
        end else if (sym == (mLast + 1) % 4) begin
            mLast = sym;
            detEv = (sym == 3);
        end else begin
            mLast = -1;
            errEv = 1'b1;
        end
        if (clr) begin
            mErr  = 1'b0;
            mCnt  = 0;
            mEcnt = 0;
        end else begin
            if (errEv) mErr = 1'b1;
            if (detEv && mCnt < 255) mCnt++;
            if (errEv && mEcnt < 255) mEcnt++;
        end
        e.det  = detEv;
        e.err  = mErr;
        e.cnt  = 8'(mCnt);
        e.ecnt = 8'(mEcnt);
        expQ.push_back(e);
    endtask

    task automatic applySeq(input int n, input int s0, input int s1, input int s2, input int s3);
        int syms[4];
        syms = '{s0, s1, s2, s3};
        for (int i = 0; i < n; i++) applyStimulus(syms[i], 1'b0);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (expQ.size() > 0 && budget < 20) begin
            @(posedge CLK1);
            budget++;
        end
        #2;
        if (expQ.size() > 0) begin
            checkOutput("drain_timeout", expQ.size(), 0);
            expQ.delete();
        end
    endtask

    // Monitor: every cycle the DUT presents fresh registered outputs just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK1);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                if (DET === 1'b1) detPulses++;
                checkOutput("DET", int'(DET), int'(e.det));
                checkOutput("ERR", int'(ERR), int'(e.err));
                checkOutput("CNT", int'(CNT), int'(e.cnt));
`ifdef FG_ERR_CNT_EN
                checkOutput("ECNT", int'(ECNT), int'(e.ecnt));
`endif
            end
        end
    end

    initial begin
        int pick;
        int nextSym;
        checks    = 0;
        errors    = 0;
        detPulses = 0;
        f   = 1'b0;
        g   = 1'b0;
        CLR = 1'b0;
        RST = 1'b0;
        modelReset();
        #12;
        checkOutput("reset_DET", int'(DET), 0);
        checkOutput("reset_ERR", int'(ERR), 0);
        checkOutput("reset_CNT", int'(CNT), 0);
        @(negedge CLK1);
        RST = 1'b1;

        // Each symbol held two cycles: one DET, CNT=1.
        for (int s = 0; s < 4; s++) begin
            applyStimulus(s, 1'b0);
            applyStimulus(s, 1'b0);
        end
        // Wrap from S3 through 00 and complete a second pass.
        applySeq(4, 3, 0, 1, 2);
        applyStimulus(3, 1'b0);
        // Out-of-order 00,01,11.
        applySeq(3, 0, 1, 3, 0);
        applyStimulus(1, 1'b0);
        // CLR on the S2->S3 edge.
        applySeq(3, 0, 1, 2, 0);
        applyStimulus(3, 1'b1);
        applyStimulus(3, 1'b0);
        drain();

        // 300 passes saturate CNT at 255.
        detPulses = 0;
        for (int i = 0; i < 300; i++) applySeq(4, 0, 1, 2, 3);
        drain();
        checkOutput("det_pulses_300", detPulses, 300);
        checkOutput("cnt_saturated", int'(CNT), 255);

        // Asynchronous reset while in S2 with ERR set.
        applySeq(3, 0, 2, 0, 0);
        applySeq(3, 0, 1, 2, 0);
        drain();
        @(posedge CLK1);
        #2;
        RST = 1'b0;
        modelReset();
        #1;
        checkOutput("async_DET", int'(DET), 0);
        checkOutput("async_ERR", int'(ERR), 0);
        checkOutput("async_CNT", int'(CNT), 0);
        #4;
        RST = 1'b1;
        applyStimulus(3, 1'b0);
        applySeq(4, 0, 1, 2, 3);
        drain();

        // Biased random symbols with occasional clear.
        for (int i = 0; i < 500; i++) begin
            pick    = int'($urandom_range(0, 99));
            nextSym = (mLast < 0) ? 0 : (mLast + 1) % 4;
            if (pick < 60) begin
                applyStimulus(nextSym, ($urandom_range(0, 99) < 3));
            end else if (pick < 80 && mLast >= 0) begin
                applyStimulus(mLast, ($urandom_range(0, 99) < 3));
            end else begin
                applyStimulus(int'($urandom_range(0, 3)), ($urandom_range(0, 99) < 3));
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
